ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter, the send direction of the PS/2 link whose receive direction is handled by the mouse receiver.
- Sends one command byte (e.g. 0xF4 "enable data reporting" or 0xFF "reset") to the mouse over the open-drain PS2_CLK/PS2_DAT pair, then checks the device acknowledge.
- The top level ANDs the open-drain enables into the tri-states of PS2_CLK/PS2_DAT.
- o_busy gates the receiver so it ignores traffic while a frame is being sent.

---
 rtl/ps2_host_tx.sv | 164 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/8 data/odd parity/stop
// on device-generated clock falls, then samples the device acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_ok,
    output logic       o_timeout,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_low,
    output logic       o_ps2_dat_low
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                             ((TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES) :
                             ((INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit_idx;
    logic [9:0]    r_frame;
    logic          r_dat_low;
    logic          r_done;
    logic          r_ack_ok;
    logic          r_timeout;
    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt, r_filt_d;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;
    logic          w_accept;

    assign w_fall   = r_filt_d & ~r_filt;
    // The o_done cycle still counts as busy, so a start there is dropped.
    assign w_accept = (r_state == S_IDLE) && !r_done && i_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt     <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_dat;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            // The filtered clock flips only after FILTER_LEN consecutive differing samples.
            if (r_clk_s2 == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt     <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_frame   <= '0;
            r_dat_low <= 1'b0;
            r_done    <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_INHIBIT;
                        r_frame   <= {1'b1, ~^i_data, i_data};
                        r_cnt     <= '0;
                        r_ack_ok  <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                        r_state   <= S_REQ;
                        r_cnt     <= '0;
                        r_dat_low <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
                        r_state   <= S_SEND;
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SEND, S_ACK, S_WAIT: begin
                    // Timeout is checked first so it beats a coincident acknowledge fall.
                    if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= S_IDLE;
                        r_dat_low <= 1'b0;
                        r_done    <= 1'b1;
                        r_ack_ok  <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_state == S_SEND) begin
                            if (w_fall) begin
                                r_dat_low <= ~r_frame[0];
                                r_frame   <= {1'b0, r_frame[9:1]};
                                r_bit_idx <= r_bit_idx + 1'b1;
                                if (r_bit_idx == 4'd9) begin
                                    r_state <= S_ACK;
                                end
                            end
                        end else if (r_state == S_ACK) begin
                            if (w_fall) begin
                                r_ack_ok <= ~r_dat_s2;
                                r_state  <= S_WAIT;
                            end
                        end else if (r_filt && r_dat_s2) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_dat_low <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE) || r_done;
    assign o_done        = r_done;
    assign o_ack_ok      = r_ack_ok;
    assign o_timeout     = r_timeout;
    assign o_ps2_clk_low = (r_state == S_INHIBIT) || (r_state == S_REQ);
    assign o_ps2_dat_low = r_dat_low;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host,
// a scoreboard queue holds the expected ack/timeout of each frame.
module tb_ps2_host_tx;
    localparam int INH  = 100;
    localparam int SET  = 10;
    localparam int TO   = 2000;
    localparam int FL   = 4;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_start = 1'b0;
    logic       o_busy, o_done, o_ack_ok, o_timeout, o_ps2_clk_low, o_ps2_dat_low;
    logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0, glitch_low = 1'b0;
    wire        ps2_clk_line = ~(o_ps2_clk_low | dev_clk_low | glitch_low);
    wire        ps2_dat_line = ~(o_ps2_dat_low | dev_dat_low);

    typedef struct packed {
        logic ack;
        logic to;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_err = 0;
    logic busy_chk = 1'b0;
    logic [10:0] bits;
    int cyc;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_ack_ok(o_ack_ok), .o_timeout(o_timeout),
        .i_ps2_clk(ps2_clk_line), .i_ps2_dat(ps2_dat_line),
        .o_ps2_clk_low(o_ps2_clk_low), .o_ps2_dat_low(o_ps2_dat_low)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every o_done pops one expectation.
    always @(negedge clk) begin
        if (busy_chk) begin
            chk("busy_after_done", {31'd0, o_busy}, 0);
            busy_chk = 1'b0;
        end
        if (o_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                $display("frame done: ack_ok=%0d timeout=%0d (expected %0d/%0d)",
                         o_ack_ok, o_timeout, mon_e.ack, mon_e.to);
                chk("ack_ok", {31'd0, o_ack_ok}, {31'd0, mon_e.ack});
                chk("timeout", {31'd0, o_timeout}, {31'd0, mon_e.to});
                chk("busy_in_done", {31'd0, o_busy}, 1);
                chk("lines_released", {30'd0, o_ps2_clk_low, o_ps2_dat_low}, 0);
                busy_chk = 1'b1;
            end
        end
    end

    // Issue a command and measure the inhibit/request phases; returns at the release cycle.
    task automatic start_cmd(input logic [7:0] d, input logic ack, input logic to);
        exp_t e;
        int n;
        int m;
        e.ack = ack;
        e.to  = to;
        @(negedge clk);
        i_data  = d;
        i_start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        while (o_ps2_clk_low && !o_ps2_dat_low && n < 10000) begin
            n++;
            @(negedge clk);
        end
        m = 0;
        while (o_ps2_clk_low && o_ps2_dat_low && m < 10000) begin
            m++;
            @(negedge clk);
        end
        chk("inhibit_cycles", n, INH);
        chk("setup_cycles", m, SET);
    endtask

    task automatic device_xfer(input int npulse, input logic ack_low, input logic glitch,
                               output logic [10:0] got);
        int w;
        w = 0;
        got = '0;
        while (!(ps2_clk_line && !ps2_dat_line) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("device_saw_request", {31'd0, w < 5000}, 1);
        got[0] = ps2_dat_line;
        repeat (HALF) @(negedge clk);
        for (int p = 1; p <= npulse; p++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            @(negedge clk);
            got[p] = ps2_dat_line;
            if (glitch) begin
                repeat (10) @(negedge clk);
                glitch_low = 1'b1;
                repeat (2) @(negedge clk);
                glitch_low = 1'b0;
                repeat (HALF - 13) @(negedge clk);
            end else begin
                repeat (HALF - 1) @(negedge clk);
            end
        end
        if (npulse == 10) begin
            dev_dat_low = ack_low;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (o_busy && w < 3000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("busy_clears", {31'd0, o_busy}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {26'd0, o_busy, o_done, o_ack_ok, o_timeout, o_ps2_clk_low, o_ps2_dat_low}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xF4 acked: start 0, data LSB first, parity 0, stop 1
        start_cmd(8'hF4, 1'b1, 1'b0);
        device_xfer(10, 1'b1, 1'b0, bits);
        chk("frame_F4", bits, 11'b1_0_11110100_0);
        wait_idle();

        // 0xFF acked; a start in the o_done cycle must be dropped
        start_cmd(8'hFF, 1'b1, 1'b0);
        device_xfer(10, 1'b1, 1'b0, bits);
        chk("frame_FF", bits, 11'b1_1_11111111_0);
        cyc = 0;
        while (!o_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {31'd0, o_done}, 1);
        i_data  = 8'h55;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("start_in_done_ignored", {30'd0, o_ps2_clk_low, o_busy}, 0);
        repeat (3) @(negedge clk);

        // 0x00 with the device leaving DAT high in the ack slot
        start_cmd(8'h00, 1'b0, 1'b0);
        device_xfer(10, 1'b0, 1'b0, bits);
        chk("frame_00", bits, 11'b1_1_00000000_0);
        wait_idle();

        // No device: timeout exactly TO cycles after the clock release
        start_cmd(8'hF4, 1'b0, 1'b1);
        cyc = 0;
        while (!o_done && cyc < 5000) begin
            cyc++;
            @(negedge clk);
        end
        chk("timeout_latency", cyc, TO);
        wait_idle();

        // Start pulse with 0xAA during SEND is ignored
        start_cmd(8'hF4, 1'b1, 1'b0);
        fork
            device_xfer(10, 1'b1, 1'b0, bits);
            begin
                repeat (300) @(negedge clk);
                i_data  = 8'hAA;
                i_start = 1'b1;
                @(negedge clk);
                i_start = 1'b0;
            end
        join
        chk("frame_F4_busy_start", bits, 11'b1_0_11110100_0);
        wait_idle();

        // Reset after 5 bit falls: lines drop asynchronously, no o_done
        start_cmd(8'h0F, 1'b1, 1'b0);
        device_xfer(5, 1'b1, 1'b0, bits);
        chk("dat_low_bit5", {31'd0, o_ps2_dat_low}, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {28'd0, o_ps2_clk_low, o_ps2_dat_low, o_busy, o_done}, 0);
        sb_q.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        start_cmd(8'hF4, 1'b1, 1'b0);
        device_xfer(10, 1'b1, 1'b0, bits);
        chk("frame_F4_after_reset", bits, 11'b1_0_11110100_0);
        wait_idle();

        // 2-cycle clock glitches in every high phase
        start_cmd(8'hF4, 1'b1, 1'b0);
        device_xfer(10, 1'b1, 1'b1, bits);
        chk("frame_F4_glitch", bits, 11'b1_0_11110100_0);
        wait_idle();

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
